// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_arbiter
// Brief    : Shares one AXI write address/data master port between NUM_M
//            requesters. One AW is accepted at a time, forwarded registered,
//            and the W channel is then locked to the granted requester until
//            the beat count reaches the forwarded awlen.
//            Round-robin by default; define AXI_ARB_FIXED_PRIO_EN for fixed
//            priority (lowest index wins, pointer held at 0).
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_arbiter #(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         arstn,
    input  logic [NUM_M-1:0]             s_awvalid,
    output logic [NUM_M-1:0]             s_awready,
    input  logic [NUM_M*4-1:0]           s_awid,
    input  logic [NUM_M*ADDR_WIDTH-1:0]  s_awaddr,
    input  logic [NUM_M*8-1:0]           s_awlen,
    input  logic [NUM_M-1:0]             s_wvalid,
    output logic [NUM_M-1:0]             s_wready,
    input  logic [NUM_M*DATA_WIDTH-1:0]  s_wdata,
    input  logic [NUM_M-1:0]             s_wlast,
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [3:0]                   m_awid,
    output logic [ADDR_WIDTH-1:0]        m_awaddr,
    output logic [7:0]                   m_awlen,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    output logic [DATA_WIDTH-1:0]        m_wdata,
    output logic                         m_wlast
);

    localparam int IDXW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDXW-1:0]         r_ptr;
    logic [IDXW-1:0]         r_g;
    logic [7:0]              r_cnt;
    logic [3:0]              r_awid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;

    logic [IDXW-1:0]         w_sel;
    logic [IDXW-1:0]         w_idx;
    logic                    w_found;
    logic [3:0]              w_sel_id;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [7:0]              w_sel_len;
    logic                    w_g_wvalid;
    logic [DATA_WIDTH-1:0]   w_g_wdata;
    logic                    w_accept;
    logic                    w_wbeat;
    logic                    w_wend;

    // s_wlast is not used for control: the burst ends on the internal count
    logic                    w_unused_wlast;
    assign w_unused_wlast = ^s_wlast;

    assign m_awid   = r_awid;
    assign m_awaddr = r_awaddr;
    assign m_awlen  = r_awlen;

    // Pick the first asserted AW request scanning from the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_idx = IDXW'((int'(r_ptr) + k) % NUM_M);
            for (int j = 0; j < NUM_M; j++) begin
                if (!w_found && (IDXW'(j) == w_idx) && s_awvalid[j]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end
        end
    end

    // Mux out the selected AW payload and the granted requester's W signals
    always_comb begin
        w_sel_id   = '0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_g_wvalid = 1'b0;
        w_g_wdata  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (IDXW'(k) == w_sel) begin
                w_sel_id   = s_awid[k*4 +: 4];
                w_sel_addr = s_awaddr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = s_awlen[k*8 +: 8];
            end
            if (IDXW'(k) == r_g) begin
                w_g_wvalid = s_wvalid[k];
                w_g_wdata  = s_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_found;
    assign w_wbeat  = (r_state == ST_DATA) && w_g_wvalid && m_wready;
    assign w_wend   = w_wbeat && (r_cnt == r_awlen);

    // State register
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and all handshake/W-path outputs; s_awready is gated by
    // reset so nothing is offered while the block is held in reset
    always_comb begin
        w_state_nxt = r_state;
        s_awready   = '0;
        s_wready    = '0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wlast     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                for (int k = 0; k < NUM_M; k++) begin
                    s_awready[k] = arstn && w_found && (IDXW'(k) == w_sel);
                end
                if (w_found) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_wvalid = w_g_wvalid;
                m_wdata  = w_g_wdata;
                m_wlast  = (r_cnt == r_awlen);
                for (int k = 0; k < NUM_M; k++) begin
                    s_wready[k] = m_wready && (IDXW'(k) == r_g);
                end
                if (w_wend) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // AW payload capture, grant index and W beat counter
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_awid   <= '0;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_g      <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_awid   <= w_sel_id;
            r_awaddr <= w_sel_addr;
            r_awlen  <= w_sel_len;
            r_g      <= w_sel;
            r_cnt    <= '0;
        end else if (w_wbeat) begin
            // Clear on the final beat so a 256-beat burst never wraps
            r_cnt <= w_wend ? 8'd0 : (r_cnt + 8'd1);
        end
    end

`ifdef AXI_ARB_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at requester 0
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= '0;
        end
    end
`else
    // Round-robin: after a burst completes, start the next scan past the winner
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_ptr <= '0;
        end else if (w_wend) begin
            r_ptr <= IDXW'((int'(r_g) + 1) % NUM_M);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_arbiter
// Brief    : Directed + randomized bench for axi_wr_arbiter with a
//            transaction-level reference model (pending AW, beats remaining,
//            round-robin pointer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              aclk;
    logic              arstn;
    logic [N-1:0]      s_awvalid;
    logic [N-1:0]      s_awready;
    logic [N*4-1:0]    s_awid;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*8-1:0]    s_awlen;
    logic [N-1:0]      s_wvalid;
    logic [N-1:0]      s_wready;
    logic [N*DW-1:0]   s_wdata;
    logic [N-1:0]      s_wlast;
    logic              m_awvalid;
    logic              m_awready;
    logic [3:0]        m_awid;
    logic [AW-1:0]     m_awaddr;
    logic [7:0]        m_awlen;
    logic              m_wvalid;
    logic              m_wready;
    logic [DW-1:0]     m_wdata;
    logic              m_wlast;

    axi_wr_arbiter #(.NUM_M(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .arstn(arstn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wlast(s_wlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wlast(m_wlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a burst is either waiting for its AW handshake or has
    // some number of W beats left; neither means the arbiter is free.
    bit          mdl_aw_pend;
    int          mdl_left;
    int          mdl_g;
    int          mdl_ptr;
    logic [3:0]  mdl_id;
    logic [31:0] mdl_addr;
    logic [7:0]  mdl_len;
    int          last_acc;
    int          grants[$];

    int obs_beats;
    int obs_last;
    int obs_last_at;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_idle();
        return !mdl_aw_pend && (mdl_left == 0);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic mdl_reset();
        mdl_aw_pend = 1'b0;
        mdl_left    = 0;
        mdl_g       = 0;
        mdl_ptr     = 0;
        mdl_id      = '0;
        mdl_addr    = '0;
        mdl_len     = '0;
        last_acc    = -1;
    endtask

    task automatic set_aw(input int i, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
        s_awid[i*4 +: 4]    = id;
        s_awaddr[i*AW +: AW] = addr;
        s_awlen[i*8 +: 8]   = len;
    endtask

    // One clock: check every output against the model, then advance the model
    task automatic cycle();
        logic [N-1:0]  e_awready;
        logic [N-1:0]  e_wready;
        logic          e_awvalid;
        logic          e_wvalid;
        logic          e_wlast;
        logic [DW-1:0] e_wdata;
        int            sel;
        #1;
        e_awready = '0;
        e_wready  = '0;
        e_awvalid = 1'b0;
        e_wvalid  = 1'b0;
        e_wlast   = 1'b0;
        e_wdata   = '0;
        sel       = -1;
        if (arstn) begin
            if (mdl_idle()) begin
                sel = pick(s_awvalid, mdl_ptr);
                if (sel >= 0) e_awready[sel] = 1'b1;
            end else if (mdl_aw_pend) begin
                e_awvalid = 1'b1;
            end else begin
                e_wvalid        = s_wvalid[mdl_g];
                e_wdata         = s_wdata[mdl_g*DW +: DW];
                e_wready[mdl_g] = m_wready;
                e_wlast         = (mdl_left == 1);
            end
        end
        chk("s_awready", s_awready, e_awready);
        chk("s_wready",  s_wready,  e_wready);
        chk("m_awvalid", m_awvalid, e_awvalid);
        chk("m_awid",    m_awid,    mdl_id);
        chk("m_awaddr",  m_awaddr,  mdl_addr);
        chk("m_awlen",   m_awlen,   mdl_len);
        chk("m_wvalid",  m_wvalid,  e_wvalid);
        chk("m_wdata",   m_wdata,   e_wdata);
        chk("m_wlast",   m_wlast,   e_wlast);
        if (m_wvalid && m_wready) begin
            obs_beats++;
            if (m_wlast) begin
                obs_last++;
                obs_last_at = obs_beats;
            end
        end
        last_acc = -1;
        if (arstn) begin
            if (mdl_idle() && sel >= 0) begin
                mdl_aw_pend = 1'b1;
                mdl_g       = sel;
                mdl_id      = s_awid[sel*4 +: 4];
                mdl_addr    = s_awaddr[sel*AW +: AW];
                mdl_len     = s_awlen[sel*8 +: 8];
                grants.push_back(sel);
                last_acc    = sel;
            end else if (mdl_aw_pend && m_awready) begin
                mdl_aw_pend = 1'b0;
                mdl_left    = int'(mdl_len) + 1;
            end else if (mdl_left > 0 && s_wvalid[mdl_g] && m_wready) begin
                mdl_left--;
`ifndef AXI_ARB_FIXED_PRIO_EN
                if (mdl_left == 0) mdl_ptr = (mdl_g + 1) % N;
`endif
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic issue(input int i);
        s_awvalid[i] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (last_acc == i) break;
        end
        s_awvalid[i] = 1'b0;
    endtask

    task automatic drain(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (mdl_idle()) break;
            cycle();
        end
    endtask

    task automatic clr_obs();
        obs_beats   = 0;
        obs_last    = 0;
        obs_last_at = 0;
    endtask

    initial begin
        arstn     = 1'b0;
        s_awvalid = '1;
        s_awid    = '0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_wvalid  = '0;
        s_wdata   = '0;
        s_wlast   = '0;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        mdl_reset();
        clr_obs();

        // Reset state, with requests pending during reset
        @(posedge aclk);
        #1;
        cycle();
        cycle();
        arstn     = 1'b1;
        s_awvalid = '0;
        cycle();

        // Simultaneous requests, len=0, held every cycle
        set_aw(0, 4'h1, 32'h0000_0010, 8'd0);
        set_aw(1, 4'h2, 32'h0000_0020, 8'd0);
        s_awvalid = '1;
        s_wvalid  = '1;
        grants.delete();
        repeat (12) cycle();
        chk("grant_count_ge4", 64'(grants.size() >= 4), 64'd1);
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            chk("grant_seq", 64'(grants[k]), 64'd0);
`else
            chk("grant_seq", 64'(grants[k]), 64'(k % 2));
`endif
        end
        s_awvalid = '0;
        s_wvalid  = '0;
        drain(20);

        // Single request from requester 0
        set_aw(0, 4'h3, 32'h0000_0100, 8'd3);
        clr_obs();
        issue(0);
        chk("single_awvalid", m_awvalid, 1);
        chk("single_awid",    m_awid, 3);
        chk("single_awaddr",  m_awaddr, 32'h100);
        chk("single_awlen",   m_awlen, 3);
        s_wvalid = 2'b01;
        drain(20);
        chk("single_beats", obs_beats, 4);
        chk("single_wlast_count", obs_last, 1);
        chk("single_wlast_at", obs_last_at, 4);
        s_wvalid = '0;

        // Backpressure on AW, then toggling W ready
        set_aw(1, 4'h5, 32'h0000_2000, 8'd4);
        m_awready = 1'b0;
        clr_obs();
        issue(1);
        set_aw(0, 4'h9, 32'h0000_9000, 8'd1);
        s_awvalid = '1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_awaddr", m_awaddr, 32'h2000);
            chk("bp_awready", s_awready, 0);
        end
        s_awvalid = '0;
        m_awready = 1'b1;
        cycle();
        s_wvalid = 2'b10;
        for (int k = 0; k < 40; k++) begin
            if (mdl_idle()) break;
            m_wready = (k % 2 == 0);
            cycle();
        end
        m_wready = 1'b1;
        chk("bp_beats", obs_beats, 5);
        chk("bp_wlast_at", obs_last_at, 5);

        // Early W from requester 1 before its AW
        s_wvalid = 2'b10;
        s_wdata  = {32'hCAFE_0001, 32'hBEEF_0000};
        #1;
        chk("early_sready", s_wready, 0);
        chk("early_mwvalid", m_wvalid, 0);
        repeat (3) cycle();
        set_aw(1, 4'h6, 32'h0000_3000, 8'd2);
        clr_obs();
        issue(1);
        drain(20);
        chk("early_beats", obs_beats, 3);

        // Length boundaries
        s_wvalid = 2'b01;
        set_aw(0, 4'h7, 32'h0000_4000, 8'd0);
        clr_obs();
        issue(0);
        drain(10);
        chk("len0_beats", obs_beats, 1);
        chk("len0_wlast", obs_last, 1);
        set_aw(0, 4'h8, 32'h0000_5000, 8'd255);
        clr_obs();
        issue(0);
        drain(300);
        chk("len255_beats", obs_beats, 256);
        chk("len255_wlast_count", obs_last, 1);
        chk("len255_wlast_at", obs_last_at, 256);

        // Reset at beat 2 of a len=7 burst from requester 1 (pointer is 1 here)
        s_wvalid = 2'b10;
        set_aw(1, 4'hA, 32'h0000_7000, 8'd7);
        issue(1);
        cycle();
        cycle();
        cycle();
        set_aw(0, 4'hB, 32'h0000_8000, 8'd1);
        s_awvalid = '1;
        arstn     = 1'b0;
        #1;
        chk("rst_s_awready", s_awready, 0);
        chk("rst_s_wready",  s_wready, 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_awid",    m_awid, 0);
        chk("rst_m_awaddr",  m_awaddr, 0);
        chk("rst_m_awlen",   m_awlen, 0);
        chk("rst_m_wvalid",  m_wvalid, 0);
        chk("rst_m_wdata",   m_wdata, 0);
        chk("rst_m_wlast",   m_wlast, 0);
        mdl_reset();
        cycle();
        cycle();
        arstn = 1'b1;
        #1;
        chk("rst_regrant", s_awready, 2'b01);
        cycle();
        s_awvalid = '0;
        drain(20);

        // Randomized traffic
        s_wvalid = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_awvalid[i] && $urandom_range(3) == 0) begin
                    set_aw(i, 4'($urandom), $urandom, 8'($urandom_range(3)));
                    s_awvalid[i] = 1'b1;
                end
            end
            s_wvalid  = N'($urandom);
            s_wdata   = {$urandom, $urandom};
            s_wlast   = N'($urandom);
            m_awready = ($urandom_range(3) != 0);
            m_wready  = ($urandom_range(3) != 0);
            cycle();
            if (last_acc >= 0) s_awvalid[last_acc] = 1'b0;
        end
        s_awvalid = '0;
        s_wvalid  = '1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        drain(50);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
